// File: rtl/gpio_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_frame_pkg
//  Description : Shared command codes, status-word bit positions and FSM
//                state encoding for the GPIO frame buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpio_frame_pkg;

  // Command codes carried in the command field of the GPIO word
  localparam int unsigned CMD_KERNEL_SEL     = 0;
  localparam int unsigned CMD_LOAD_FRAME     = 1;
  localparam int unsigned CMD_END_FRAME      = 2;
  localparam int unsigned CMD_IS_FRAME_READY = 3;
  localparam int unsigned CMD_GET_FRAME      = 4;

  // Status response layout: five flags on top, three zero bits, load pointer
  localparam int unsigned STAT_W            = 24;
  localparam int unsigned STAT_FRAME_VALID  = 23;
  localparam int unsigned STAT_RESULT_READY = 22;
  localparam int unsigned STAT_OVERFLOW     = 21;
  localparam int unsigned STAT_CMD_DROP     = 20;
  localparam int unsigned STAT_BAD_CMD      = 19;

  // Command FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_WR = 2'd1,
    ST_GET_RD  = 2'd2,
    ST_RESP    = 2'd3
  } fsm_state_e;

  // Assemble the IS_FRAME_READY response word
  function automatic logic [STAT_W-1:0] pack_status(
    input logic        frame_valid,
    input logic        result_ready,
    input logic        overflow,
    input logic        cmd_drop,
    input logic        bad_cmd,
    input logic [15:0] load_ptr
  );
    logic [STAT_W-1:0] s;
    s                    = '0;
    s[STAT_FRAME_VALID]  = frame_valid;
    s[STAT_RESULT_READY] = result_ready;
    s[STAT_OVERFLOW]     = overflow;
    s[STAT_CMD_DROP]     = cmd_drop;
    s[STAT_BAD_CMD]      = bad_cmd;
    s[15:0]              = load_ptr;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_frame_buffer_frame_ram.sv
`default_nettype none
// ============================================================================
//  Module      : frame_ram
//  Description : Synchronous simple dual-port RAM, DEPTH x WIDTH. One write
//                port, one registered read port (1-cycle latency). Accesses
//                beyond DEPTH are ignored on write and read back as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_ram
  import gpio_frame_pkg::*;
#(
  parameter int DEPTH  = 100,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: out-of-range addresses are silently dropped
  always_ff @(posedge clk_i) begin
    if (we_i && ({1'b0, waddr_i} < DEPTH_C)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port: out-of-range addresses return zero
  always_ff @(posedge clk_i) begin
    if ({1'b0, raddr_i} < DEPTH_C) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/gpio_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_frame_buffer
//  Description : GPIO command front end for an image core. Host commands
//                arrive on gpi0 as a strobed word; pixels are packed into an
//                input bank for the core, results are read back from a result
//                bank, and every accepted command is answered on gpo0 with an
//                ack toggle.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_frame_buffer
  import gpio_frame_pkg::*;
#(
  parameter int NB_GPIOS     = 32,
  parameter int NB_COM       = 7,
  parameter int RAM_WIDTH    = 8,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10,
  parameter int PX_PER_WORD  = 3,
  parameter int NB_KSEL      = 2
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [NB_GPIOS-1:0]                          gpi0,
  output logic [NB_GPIOS-1:0]                          gpo0,
  output logic [NB_KSEL-1:0]                           kernel_sel_o,
  output logic                                         frame_valid_o,
  output logic                                         core_start_o,
  input  logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT)-1:0]  core_rd_addr_i,
  output logic [RAM_WIDTH-1:0]                         core_rd_data_o,
  input  logic                                         core_wr_en_i,
  input  logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT)-1:0]  core_wr_addr_i,
  input  logic [RAM_WIDTH-1:0]                         core_wr_data_i,
  input  logic                                         core_done_i
);

  localparam int N        = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int ADDR_W   = $clog2(N);
  localparam int PTR_W    = $clog2(N + 1);
  localparam int NB_DATA  = NB_GPIOS - 1 - NB_COM;
  localparam int PIX_BITS = PX_PER_WORD * RAM_WIDTH;
  localparam int CNT_W    = $clog2(PX_PER_WORD + 1);

  localparam logic [PTR_W-1:0] N_PTR  = PTR_W'(N);
  localparam logic [CNT_W-1:0] PX_C   = CNT_W'(PX_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(PX_PER_WORD - 1);

  // Input register and strobe edge detection
  logic [NB_GPIOS-1:0] gpi_q;
  logic                strb_prev_q;
  logic                strobe_edge;
  logic [NB_COM-1:0]   gpi_cmd;

  // Command context
  fsm_state_e          state_q;
  logic [NB_COM-1:0]   cmd_q;
  logic [PIX_BITS-1:0] data_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NB_DATA-1:0]  resp_data_q;
  logic                rd_ok_q;

  // Pointers, flags and outputs
  logic [PTR_W-1:0]    load_ptr_q;
  logic [PTR_W-1:0]    get_ptr_q;
  logic [NB_KSEL-1:0]  kernel_sel_q;
  logic                frame_valid_q;
  logic                core_start_q;
  logic                result_ready_q;
  logic                overflow_q;
  logic                cmd_drop_q;
  logic                bad_cmd_q;
  logic [NB_GPIOS-1:0] gpo_q;

  // RAM side signals
  logic                in_we;
  logic [RAM_WIDTH-1:0] ld_pix;
  logic [RAM_WIDTH-1:0] res_rdata;
  logic [STAT_W-1:0]    status_word;

  assign strobe_edge = gpi_q[NB_GPIOS-1] & ~strb_prev_q;
  assign gpi_cmd     = gpi_q[NB_GPIOS-2 -: NB_COM];
  assign status_word = pack_status(frame_valid_q, result_ready_q, overflow_q,
                                   cmd_drop_q, bad_cmd_q, 16'(load_ptr_q));

  // Writes stop once the input bank is full; the pixel is simply discarded
  assign in_we = (state_q == ST_LOAD_WR) && (load_ptr_q != N_PTR);

  // Select the pixel of the captured word that belongs to the current slot
  always_comb begin
    ld_pix = '0;
    for (int k = 0; k < PX_PER_WORD; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        ld_pix = data_q[k*RAM_WIDTH +: RAM_WIDTH];
      end
    end
  end

  // Command FSM: capture, pixel load/readback, and response generation
  always_ff @(posedge clock) begin
    if (reset) begin
      gpi_q          <= '0;
      strb_prev_q    <= 1'b0;
      state_q        <= ST_IDLE;
      cmd_q          <= '0;
      data_q         <= '0;
      cnt_q          <= '0;
      resp_data_q    <= '0;
      rd_ok_q        <= 1'b0;
      load_ptr_q     <= '0;
      get_ptr_q      <= '0;
      kernel_sel_q   <= '0;
      frame_valid_q  <= 1'b0;
      core_start_q   <= 1'b0;
      result_ready_q <= 1'b0;
      overflow_q     <= 1'b0;
      cmd_drop_q     <= 1'b0;
      bad_cmd_q      <= 1'b0;
      gpo_q          <= '0;
    end else begin
      gpi_q        <= gpi0;
      strb_prev_q  <= gpi_q[NB_GPIOS-1];
      core_start_q <= 1'b0;

      // Placed before the command decode so an END_FRAME clear overrides it
      if (core_done_i) begin
        result_ready_q <= 1'b1;
      end

      if (strobe_edge && (state_q != ST_IDLE)) begin
        cmd_drop_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (strobe_edge) begin
            cmd_q       <= gpi_cmd;
            data_q      <= gpi_q[PIX_BITS-1:0];
            cnt_q       <= '0;
            resp_data_q <= '0;
            if (gpi_cmd == NB_COM'(CMD_KERNEL_SEL)) begin
              kernel_sel_q <= gpi_q[NB_KSEL-1:0];
              state_q      <= ST_RESP;
            end else if (gpi_cmd == NB_COM'(CMD_LOAD_FRAME)) begin
              frame_valid_q <= 1'b0;
              state_q       <= ST_LOAD_WR;
            end else if (gpi_cmd == NB_COM'(CMD_END_FRAME)) begin
              frame_valid_q  <= 1'b1;
              core_start_q   <= 1'b1;
              load_ptr_q     <= '0;
              get_ptr_q      <= '0;
              result_ready_q <= 1'b0;
              overflow_q     <= 1'b0;
              state_q        <= ST_RESP;
            end else if (gpi_cmd == NB_COM'(CMD_IS_FRAME_READY)) begin
              state_q <= ST_RESP;
            end else if (gpi_cmd == NB_COM'(CMD_GET_FRAME)) begin
              state_q <= ST_GET_RD;
            end else begin
              bad_cmd_q <= 1'b1;
              state_q   <= ST_RESP;
            end
          end
        end

        ST_LOAD_WR: begin
          if (load_ptr_q == N_PTR) begin
            overflow_q <= 1'b1;
          end else begin
            load_ptr_q <= load_ptr_q + PTR_W'(1);
          end
          if (cnt_q == LAST_C) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        // Issue slots 0..PX-1 and collect slots 1..PX, one cycle behind
        ST_GET_RD: begin
          if (cnt_q != PX_C) begin
            if (get_ptr_q != N_PTR) begin
              rd_ok_q   <= 1'b1;
              get_ptr_q <= get_ptr_q + PTR_W'(1);
            end else begin
              rd_ok_q <= 1'b0;
            end
          end
          for (int k = 0; k < PX_PER_WORD; k++) begin
            if (cnt_q == CNT_W'(k + 1)) begin
              resp_data_q[k*RAM_WIDTH +: RAM_WIDTH] <= rd_ok_q ? res_rdata : '0;
            end
          end
          if (cnt_q == PX_C) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (cmd_q == NB_COM'(CMD_IS_FRAME_READY)) begin
            gpo_q <= {~gpo_q[NB_GPIOS-1], cmd_q, NB_DATA'(status_word)};
          end else begin
            gpo_q <= {~gpo_q[NB_GPIOS-1], cmd_q, resp_data_q};
          end
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gpo0          = gpo_q;
  assign kernel_sel_o  = kernel_sel_q;
  assign frame_valid_o = frame_valid_q;
  assign core_start_o  = core_start_q;

  frame_ram #(
    .DEPTH  (N),
    .WIDTH  (RAM_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_in_ram (
    .clk_i   (clock),
    .we_i    (in_we),
    .waddr_i (load_ptr_q[ADDR_W-1:0]),
    .wdata_i (ld_pix),
    .raddr_i (core_rd_addr_i),
    .rdata_o (core_rd_data_o)
  );

  frame_ram #(
    .DEPTH  (N),
    .WIDTH  (RAM_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_res_ram (
    .clk_i   (clock),
    .we_i    (core_wr_en_i),
    .waddr_i (core_wr_addr_i),
    .wdata_i (core_wr_data_i),
    .raddr_i (get_ptr_q[ADDR_W-1:0]),
    .rdata_o (res_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_gpio_frame_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_gpio_frame_buffer
//  Description : Scoreboard bench for gpio_frame_buffer. Commands are applied
//                to a behavioural model that pushes the expected gpo0 word and
//                its due cycle; a monitor pops and compares on every ack
//                toggle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_frame_buffer;

  localparam int N  = 100;
  localparam int PX = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] gpi0  = '0;
  logic [31:0] gpo0;
  logic [1:0]  kernel_sel_o;
  logic        frame_valid_o;
  logic        core_start_o;
  logic [6:0]  core_rd_addr_i = '0;
  logic [7:0]  core_rd_data_o;
  logic        core_wr_en_i   = 1'b0;
  logic [6:0]  core_wr_addr_i = '0;
  logic [7:0]  core_wr_data_i = '0;
  logic        core_done_i    = 1'b0;

  gpio_frame_buffer dut (
    .clock          (clock),
    .reset          (reset),
    .gpi0           (gpi0),
    .gpo0           (gpo0),
    .kernel_sel_o   (kernel_sel_o),
    .frame_valid_o  (frame_valid_o),
    .core_start_o   (core_start_o),
    .core_rd_addr_i (core_rd_addr_i),
    .core_rd_data_o (core_rd_data_o),
    .core_wr_en_i   (core_wr_en_i),
    .core_wr_addr_i (core_wr_addr_i),
    .core_wr_data_i (core_wr_data_i),
    .core_done_i    (core_done_i)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks    = 0;
  int failures  = 0;
  int start_cnt = 0;

  typedef struct {
    logic [31:0] word;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  // Behavioural model state
  int         m_lp, m_gp;
  bit         m_fv, m_rr, m_ov, m_drop, m_bad, m_ack;
  logic [1:0] m_ksel;
  logic [7:0] m_in  [N];
  bit         m_known [N];
  logic [7:0] m_res [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_lp = 0; m_gp = 0;
    m_fv = 0; m_rr = 0; m_ov = 0; m_drop = 0; m_bad = 0; m_ack = 0;
    m_ksel = '0;
  endfunction

  // Apply a command to the model and queue the response expected from it
  function automatic void model_cmd(input logic [6:0] cmd, input logic [23:0] data, input int base);
    logic [23:0] r;
    int          lat;
    exp_t        e;
    r   = '0;
    lat = 2;
    case (cmd)
      7'd0: m_ksel = data[1:0];
      7'd1: begin
        lat  = PX + 2;
        m_fv = 0;
        for (int k = 0; k < PX; k++) begin
          if (m_lp < N) begin
            m_in[m_lp]    = data[k*8 +: 8];
            m_known[m_lp] = 1;
            m_lp++;
          end else begin
            m_ov = 1;
          end
        end
      end
      7'd2: begin
        m_fv = 1; m_lp = 0; m_gp = 0; m_rr = 0; m_ov = 0;
      end
      7'd3: r = {m_fv, m_rr, m_ov, m_drop, m_bad, 3'b000, 16'(m_lp)};
      7'd4: begin
        lat = PX + 3;
        for (int k = 0; k < PX; k++) begin
          if (m_gp < N) begin
            r[k*8 +: 8] = m_res[m_gp];
            m_gp++;
          end
        end
      end
      default: m_bad = 1;
    endcase
    m_ack  = ~m_ack;
    e.word = {m_ack, cmd, r};
    e.due  = base + 1 + lat;
    sb_q.push_back(e);
  endfunction

  // Monitor: every ack toggle is one response to compare
  logic mon_ack = 1'b0;
  exp_t mon_e;
  always @(negedge clock) begin
    if (reset) begin
      mon_ack = gpo0[31];
    end else if (gpo0[31] !== mon_ack) begin
      mon_ack = gpo0[31];
      if (sb_q.size() == 0) begin
        check("unexpected_response", gpo0, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("gpo0_word", gpo0, mon_e.word);
        check("gpo0_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  task automatic drive_cmd(input logic [6:0] cmd, input logic [23:0] data, input bit done_at_accept);
    gpi0 = {1'b1, cmd, data};
    @(negedge clock);
    if (core_start_o) start_cnt++;
    gpi0[31]    = 1'b0;
    core_done_i = done_at_accept;
    if (done_at_accept) begin
      @(negedge clock);
      if (core_start_o) start_cnt++;
      core_done_i = 1'b0;
    end
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) begin
      @(negedge clock);
      if (core_start_o) start_cnt++;
    end
    if (sb_q.size() != 0) begin
      check("response_timeout", 32'(sb_q.size()), 32'h0);
      sb_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic send(input logic [6:0] cmd, input logic [23:0] data);
    start_cnt = 0;
    model_cmd(cmd, data, cyc);
    drive_cmd(cmd, data, 1'b0);
    wait_resp();
    check("frame_valid_o", 32'(frame_valid_o), 32'(m_fv));
    check("kernel_sel_o", 32'(kernel_sel_o), 32'(m_ksel));
    check("core_start_pulses", 32'(start_cnt), (cmd == 7'd2) ? 32'd1 : 32'd0);
  endtask

  task automatic core_write(input logic [6:0] addr, input logic [7:0] data);
    core_wr_en_i   = 1'b1;
    core_wr_addr_i = addr;
    core_wr_data_i = data;
    if (int'(addr) < N) m_res[addr] = data;
    @(negedge clock);
    core_wr_en_i = 1'b0;
  endtask

  task automatic core_done_pulse();
    core_done_i = 1'b1;
    m_rr        = 1;
    @(negedge clock);
    core_done_i = 1'b0;
  endtask

  task automatic core_read_check(input int addr);
    core_rd_addr_i = 7'(addr);
    @(negedge clock);
    check("core_rd_data", 32'(core_rd_data_o), 32'(m_in[addr]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      m_in[i] = '0; m_known[i] = 0; m_res[i] = '0;
    end
    model_reset();

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_gpo0", gpo0, 32'h0);
    check("rst_kernel_sel", 32'(kernel_sel_o), 32'h0);
    check("rst_frame_valid", 32'(frame_valid_o), 32'h0);
    check("rst_core_start", 32'(core_start_o), 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Kernel select
    send(7'd0, 24'd2);
    check("ksel_value", 32'(kernel_sel_o), 32'd2);

    // 34 loads of pixels 0..101, then status shows overflow and full pointer
    for (int i = 0; i < 34; i++) begin
      send(7'd1, {8'(3*i+2), 8'(3*i+1), 8'(3*i)});
    end
    send(7'd3, 24'd0);

    // End of frame: start pulse, frame valid, core reads the input bank
    send(7'd2, 24'd0);
    core_read_check(57);
    core_read_check(0);
    core_read_check(99);

    // Core writes the result frame, signals done, host reads it back
    for (int i = 0; i < N; i++) core_write(7'(i), 8'(255 - i));
    core_write(7'd120, 8'hAA);
    core_done_pulse();
    send(7'd3, 24'd0);
    for (int g = 0; g < 35; g++) send(7'd4, 24'd0);
    send(7'd3, 24'd0);

    // core_done coinciding with END_FRAME: the clear wins
    core_done_pulse();
    start_cnt = 0;
    model_cmd(7'd2, 24'd0, cyc);
    drive_cmd(7'd2, 24'd0, 1'b1);
    wait_resp();
    check("end_done_start_pulses", 32'(start_cnt), 32'd1);
    send(7'd3, 24'd0);

    // Second strobe during LOAD_WR is dropped
    model_cmd(7'd1, 24'h332211, cyc);
    drive_cmd(7'd1, 24'h332211, 1'b0);
    @(negedge clock);
    gpi0 = {1'b1, 7'd0, 24'h000003};
    @(negedge clock);
    gpi0[31] = 1'b0;
    m_drop   = 1;
    wait_resp();
    check("drop_ksel_unchanged", 32'(kernel_sel_o), 32'(m_ksel));
    send(7'd3, 24'd0);

    // Unknown command code
    send(7'd7, 24'h5A5A5A);
    send(7'd3, 24'd0);

    // Reset in the middle of LOAD_WR
    for (int k = 0; k < PX; k++) if (m_lp + k < N) m_known[m_lp + k] = 0;
    gpi0 = {1'b1, 7'd1, 24'hC0FFEE};
    @(negedge clock);
    gpi0[31] = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("midrst_gpo0", gpo0, 32'h0);
    check("midrst_kernel_sel", 32'(kernel_sel_o), 32'h0);
    check("midrst_frame_valid", 32'(frame_valid_o), 32'h0);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    send(7'd3, 24'd0);
    send(7'd4, 24'd0);

    // Randomized command mix
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 9))
        0:       send(7'd0, 24'($urandom));
        1, 2:    send(7'd1, 24'($urandom));
        3:       send(7'd2, 24'd0);
        4:       send(7'd3, 24'd0);
        5:       send(7'd4, 24'd0);
        6:       send(7'($urandom_range(5, 127)), 24'($urandom));
        7: begin
          for (int j = 0; j < 4; j++) core_write(7'($urandom_range(0, 127)), 8'($urandom));
        end
        8:       core_done_pulse();
        default: begin
          int a;
          a = $urandom_range(0, N - 1);
          if (m_known[a]) core_read_check(a);
        end
      endcase
    end
    send(7'd3, 24'd0);

    repeat (4) @(negedge clock);
    check("scoreboard_drain", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_frame_buffer.md
GPIO_FRAME_BUFFER -- requirements
Module: gpio_frame_buffer

Interface
REQ-001 Reset is synchronous and active-high on `reset`; there is one clock, `clock`, and all logic is on its rising edge.
REQ-002 Parameter NB_GPIOS, default 32: width of the GPIO command/response words.
REQ-003 Parameter NB_COM, default 7: command field width; NB_DATA = NB_GPIOS-1-NB_COM (24).
REQ-004 Parameter RAM_WIDTH, default 8: pixel width in bits.
REQ-005 Parameters IMAGE_WIDTH and IMAGE_HEIGHT, default 10 each: frame size; N = IMAGE_WIDTH*IMAGE_HEIGHT, and clog2(N+1) SHALL be at most 16.
REQ-006 Parameter PX_PER_WORD, default 3: pixels per command, legal range 1..NB_DATA/RAM_WIDTH.
REQ-007 Parameter NB_KSEL, default 2: kernel-select width.
REQ-008 Ports, one per line:
  clock  in  1  system clock
  reset  in  1  synchronous active-high reset
  gpi0  in  NB_GPIOS  bit[31] strobe, [30:24] command, [23:0] data
  gpo0  out  NB_GPIOS  bit[31] ack toggle, [30:24] command echo, [23:0] response data
  kernel_sel_o  out  NB_KSEL  selected kernel
  frame_valid_o  out  1  input frame complete
  core_start_o  out  1  one-cycle start pulse to the core
  core_rd_addr_i  in  clog2(N)  input-bank read address
  core_rd_data_o  out  RAM_WIDTH  input-bank read data
  core_wr_en_i / core_wr_addr_i / core_wr_data_i  in  1 / clog2(N) / RAM_WIDTH  result-bank write port
  core_done_i  in  1  result frame complete

Function
REQ-009 gpi0 SHALL be registered once; a command is accepted on a 0->1 transition of the registered bit[31], with the command and data captured in that same cycle.
REQ-010 Command codes: KERNEL_SEL=0, LOAD_FRAME=1, END_FRAME=2, IS_FRAME_READY=3, GET_FRAME=4; any other code is a bad command.
REQ-011 FSM states are IDLE, LOAD_WR, GET_RD, RESP; only IDLE accepts commands.
REQ-012 A strobe edge seen outside IDLE SHALL be dropped and SHALL set the sticky flag cmd_drop.
REQ-013 KERNEL_SEL: kernel_sel_o <= data[NB_KSEL-1:0]; go to RESP.
REQ-014 LOAD_FRAME: in LOAD_WR, write pixel k = data[k*RAM_WIDTH +: RAM_WIDTH] to input-bank address load_ptr, one pixel per cycle, for k = 0..PX_PER_WORD-1, incrementing load_ptr; then go to RESP.
REQ-015 LOAD_FRAME when load_ptr = N: the pixel is discarded, overflow is set sticky, and load_ptr saturates at N.
REQ-016 LOAD_FRAME while frame_valid_o=1: clear frame_valid_o before the first write.
REQ-017 END_FRAME: frame_valid_o <= 1, one-cycle core_start_o, load_ptr <= 0, get_ptr <= 0, result_ready <= 0, overflow <= 0.
REQ-018 IS_FRAME_READY: response data = {frame_valid, result_ready, overflow, cmd_drop, bad_cmd, 3'b0, load_ptr[15:0]}.
REQ-019 GET_FRAME: in GET_RD, read PX_PER_WORD result-bank pixels from get_ptr (1-cycle RAM latency) and pack pixel k at data[k*RAM_WIDTH +: RAM_WIDTH]; addresses >= N return 0; get_ptr saturates at N.
REQ-020 GET_FRAME: each command returns the next group with no repeated first group; unused data bits are 0.
REQ-021 RESP: update gpo0 {~ack, command, data} in one cycle, then return to IDLE.
REQ-022 Latency from strobe edge to gpo0 update: KERNEL_SEL, END_FRAME and status commands 2 cycles; LOAD_FRAME PX_PER_WORD+2 cycles; GET_FRAME PX_PER_WORD+3 cycles.
REQ-023 Bad command: set bad_cmd sticky, response data 0, ack still toggles.
REQ-024 core_rd_data_o SHALL be valid one cycle after core_rd_addr_i.
REQ-025 The core write port is independent of the FSM; writes with address >= N are ignored.
REQ-026 core_done_i sets result_ready; if it coincides with END_FRAME, the END_FRAME clear wins.
REQ-027 cmd_drop and bad_cmd clear only on reset.

Reset
REQ-028 Reset SHALL set gpo0=0, kernel_sel_o=0, frame_valid_o=0, core_start_o=0, all pointers and flags to 0, and the FSM to IDLE.
REQ-029 Reset mid-command aborts the command; RAM contents are not cleared.

Structure
REQ-030 Command codes, status bit positions and FSM state encoding belong in shared package gpio_frame_pkg.
REQ-031 One sub-module, frame_ram (sync simple dual-port, N x RAM_WIDTH), instantiated twice: input bank and result bank.

Verification (W=H=10, PX_PER_WORD=3)
REQ-032 Reset: gpo0=0 and kernel_sel_o=0; then KERNEL_SEL data=2 -> kernel_sel_o=2, gpo0[31]=1, gpo0[30:24]=0 after 2 cycles.
REQ-033 34 LOAD_FRAME commands carrying pixels 0..101 -> IS_FRAME_READY returns overflow=1, load_ptr=100; pixels 100 and 101 are discarded.
REQ-034 END_FRAME -> core_start_o is high for exactly 1 cycle and frame_valid_o=1; core_rd_addr_i=57 -> core_rd_data_o=57 on the next cycle.
REQ-035 Core writes result[i]=255-i and pulses core_done_i -> status result_ready=1; GET #0 returns {255,254,253} at bytes 0..2; GET #33 returns {156,0,0}; GET #34 returns 0.
REQ-036 Second strobe during LOAD_WR -> command dropped and cmd_drop=1; command 7 -> bad_cmd=1 and ack toggles.
REQ-037 Reset asserted mid-LOAD_WR -> load_ptr=0, FSM in IDLE, gpo0=0.
